// File: rtl/av_mailbox_slave.sv
// Avalon-MM mailbox slave: bus DATA writes feed a TX word stream, an RX word stream feeds bus DATA reads.
// Optional MAILBOX_BLOCKING_EN stalls the bus on full TX / empty RX instead of dropping and flagging.
module mbx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  input  logic          i_push,
  input  logic [31:0]   i_wdata,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [31:0]   o_head,
  output logic [AW:0]   o_cnt,
  output logic          o_full,
  output logic          o_empty
);
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;

  // Storage is deliberately not reset; the head is gated while empty instead.
  always_ff @(posedge i_Clk)
    if (i_push) r_mem[r_wp] <= i_wdata;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n || i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = o_empty ? '0 : r_mem[r_rp];
  assign o_cnt   = r_cnt;
endmodule

module av_mailbox_slave #(
  parameter int DEPTH = 8
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [29:0] i_AV_Addr,
  input  logic [3:0]  i_AV_ByteEn,
  input  logic        i_AV_Read,
  input  logic        i_AV_Write,
  input  logic [31:0] i_AV_WriteData,
  output logic [31:0] o_AV_ReadData,
  output logic        o_AV_WaitRequest,
  output logic [31:0] o_Tx_Data,
  output logic        o_Tx_Valid,
  input  logic        i_Tx_Ready,
  input  logic [31:0] i_Rx_Data,
  input  logic        i_Rx_Valid,
  output logic        o_Rx_Ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } req_t;

  req_t        w_req;
  logic        w_acc_rd, w_acc_wr, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic        w_tx_flush, w_rx_flush, w_ovf_set, w_unf_set, w_stat_wr;
  logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [AW:0] w_tx_cnt, w_rx_cnt;
  logic [31:0] w_rx_head, w_status;
  logic        r_ovf, r_unf;
  logic [31:0] r_rdata;
  logic        w_unused_ok;

  assign w_req       = '{rd: i_AV_Read, wr: i_AV_Write, addr: i_AV_Addr[1:0], wdata: i_AV_WriteData};
  assign w_unused_ok = ^{i_AV_ByteEn, i_AV_Addr[29:2]};

`ifdef MAILBOX_BLOCKING_EN
  // Stall only on registered full/empty so no stream input reaches waitrequest.
  assign o_AV_WaitRequest = (w_req.addr == A_DATA) &&
                            ((w_req.wr && w_tx_full) || (w_req.rd && w_rx_empty));
`else
  assign o_AV_WaitRequest = 1'b0;
`endif

  assign w_acc_rd   = w_req.rd && !o_AV_WaitRequest;
  assign w_acc_wr   = w_req.wr && !o_AV_WaitRequest;
  assign w_tx_push  = w_acc_wr && (w_req.addr == A_DATA) && !w_tx_full;
  assign w_rx_pop   = w_acc_rd && (w_req.addr == A_DATA) && !w_rx_empty;
  assign w_tx_pop   = !w_tx_empty && i_Tx_Ready;
  assign w_rx_push  = i_Rx_Valid && !w_rx_full;
  assign w_tx_flush = w_acc_wr && (w_req.addr == A_CTRL) && w_req.wdata[0];
  assign w_rx_flush = w_acc_wr && (w_req.addr == A_CTRL) && w_req.wdata[1];
  assign w_stat_wr  = w_acc_wr && (w_req.addr == A_STAT);

`ifdef MAILBOX_BLOCKING_EN
  assign w_ovf_set = 1'b0;
  assign w_unf_set = 1'b0;
`else
  assign w_ovf_set = w_acc_wr && (w_req.addr == A_DATA) && w_tx_full;
  assign w_unf_set = w_acc_rd && (w_req.addr == A_DATA) && w_rx_empty;
`endif

  mbx_fifo #(.DEPTH(DEPTH)) u_tx (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_push(w_tx_push), .i_wdata(w_req.wdata),
    .i_pop(w_tx_pop), .i_flush(w_tx_flush), .o_head(o_Tx_Data), .o_cnt(w_tx_cnt),
    .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  mbx_fifo #(.DEPTH(DEPTH)) u_rx (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_push(w_rx_push), .i_wdata(i_Rx_Data),
    .i_pop(w_rx_pop), .i_flush(w_rx_flush), .o_head(w_rx_head), .o_cnt(w_rx_cnt),
    .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  assign o_Tx_Valid = !w_tx_empty;
  assign o_Rx_Ready = !w_rx_full;
  assign w_status   = {12'd0, r_unf, r_ovf, w_rx_empty, w_tx_full, 8'(w_rx_cnt), 8'(w_tx_cnt)};

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set)                          r_ovf <= 1'b1;
      else if (w_stat_wr && w_req.wdata[18])  r_ovf <= 1'b0;
      if (w_unf_set)                          r_unf <= 1'b1;
      else if (w_stat_wr && w_req.wdata[19])  r_unf <= 1'b0;
    end
  end

  // Read data lives for exactly one cycle after acceptance, zero otherwise.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= '0;
      if (w_acc_rd) begin
        case (w_req.addr)
          A_DATA:  r_rdata <= w_rx_head;
          A_STAT:  r_rdata <= w_status;
          default: r_rdata <= '0;
        endcase
      end
    end
  end

  assign o_AV_ReadData = r_rdata;
endmodule
